// File: rtl/mul_sequencer.sv
// mul_sequencer: iterative shift-add multiplier for the execute stage.
// Computes the low WIDTH bits of SrcAE*SrcBE (+AccE for MLA), retiring one
// multiplier bit per cycle and exiting early once the remaining multiplier
// bits are all zero.
//
// Handshake: an operation is accepted on a rising edge where StartE=1,
// FlushE=0 and the sequencer is in IDLE or DONE. StallMulE holds the front
// of the pipeline from the accept cycle until the result is ready.
// MulDoneE pulses for exactly one cycle with MulResultE/MulFlagsE valid.
// There is no back-pressure on the result. FlushE kills any in-flight
// operation and beats a simultaneous StartE.
module mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StartE,
  input  logic             MlaE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic [WIDTH-1:0] AccE,
  input  logic             FlushE,
  output logic             StallMulE,
  output logic             BusyE,
  output logic             MulDoneE,
  output logic [WIDTH-1:0] MulResultE,
  output logic [1:0]       MulFlagsE
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] prod;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] resReg;
  logic [1:0]       flagReg;

  logic             accept;
  logic [WIDTH-1:0] stepSum;
  logic [WIDTH-1:0] nextMplier;
  logic [CW-1:0]    cntNext;
  logic             runExit;
  logic [WIDTH-1:0] loadProd;

  // {N,Z} of a result value
  function automatic logic [1:0] flagsOf(input logic [WIDTH-1:0] v);
    flagsOf = {v[WIDTH-1], (v == '0)};
  endfunction

  assign accept = ((state == IDLE) || (state == DONE)) && StartE && !FlushE;

  // One shift-add step and the early-exit decision for the RUN state
  always_comb begin
    stepSum    = mplier[0] ? (prod + mcand) : prod;
    nextMplier = mplier >> 1;
    cntNext    = cnt + 1'b1;
    runExit    = (nextMplier == '0) || (cntNext == CNT_MAX);
    loadProd   = MlaE ? AccE : '0;
  end

  // Sequencer state, datapath registers and the registered result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      prod    <= '0;
      cnt     <= '0;
      resReg  <= '0;
      flagReg <= '0;
    end else if (FlushE) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            mcand  <= SrcAE;
            mplier <= SrcBE;
            prod   <= loadProd;
            cnt    <= '0;
            if (SrcBE == '0) begin
              // Zero multiplier: the result is just the accumulator
              state   <= DONE;
              resReg  <= loadProd;
              flagReg <= flagsOf(loadProd);
            end else begin
              state <= RUN;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          mcand  <= mcand << 1;
          mplier <= nextMplier;
          prod   <= stepSum;
          cnt    <= cntNext;
          if (runExit) begin
            state   <= DONE;
            resReg  <= stepSum;
            flagReg <= flagsOf(stepSum);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign StallMulE  = accept || (state == RUN);
  assign BusyE      = (state == RUN);
  assign MulDoneE   = (state == DONE);
  assign MulResultE = resReg;
  assign MulFlagsE  = flagReg;

endmodule
